// File: rtl/myproject_mac_pkg.sv
// Shared constants and output-stage helpers for the pipelined MAC.
package myproject_mac_pkg;

   localparam int unsigned MODE_MUL = 0;
   localparam int unsigned MODE_ACC = 1;
   localparam int unsigned XW       = 64;

   typedef logic signed [XW-1:0] wide_t;

   typedef struct packed {
      logic  ovf;
      wide_t value;
   } clip_t;

   // Arithmetic right shift with round-half-up; shift 0 passes x through.
   function automatic wide_t round_shift(input wide_t x, input int unsigned shift);
      wide_t half;
      wide_t r;
      r = x;
      if (shift != 0) begin
         half = wide_t'(1) <<< (shift - 1);
         r    = (x + half) >>> shift;
      end
      return r;
   endfunction

   // Clamp x into the signed range of the given width.
   function automatic clip_t sat_clip(input wide_t x, input int unsigned width);
      wide_t hi;
      wide_t lo;
      clip_t r;
      hi      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
      lo      = -hi - wide_t'(1);
      r.ovf   = 1'b0;
      r.value = x;
      if (x > hi) begin
         r.value = hi;
         r.ovf   = 1'b1;
      end else if (x < lo) begin
         r.value = lo;
         r.ovf   = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// Signed multiplier followed by NUM_STAGE enable-gated registers for DSP mapping.
module myproject_mac_mul_pipe #(
   parameter int unsigned A_WIDTH   = 16,
   parameter int unsigned B_WIDTH   = 11,
   parameter int unsigned NUM_STAGE = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic signed [A_WIDTH-1:0]         a,
   input  logic signed [B_WIDTH-1:0]         b,
   output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

   localparam int unsigned PW = A_WIDTH + B_WIDTH;

   logic signed [PW-1:0] a_x;
   logic signed [PW-1:0] b_x;
   logic signed [PW-1:0] stg [NUM_STAGE];

   assign a_x = PW'(a);
   assign b_x = PW'(b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_STAGE; i++) stg[i] <= '0;
      end else if (en) begin
         stg[0] <= a_x * b_x;
         for (int unsigned i = 1; i < NUM_STAGE; i++) stg[i] <= stg[i-1];
      end
   end

   assign p = stg[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe_sat.sv
// Pipelined signed multiply / multiply-accumulate with valid/ready handshake,
// rounding shift and saturating (or wrapping) output.
module myproject_mac_pipe_sat
   import myproject_mac_pkg::*;
#(
   parameter int unsigned DIN0_WIDTH = 16,
   parameter int unsigned DIN1_WIDTH = 11,
   parameter int unsigned NUM_STAGE  = 3,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned DOUT_WIDTH = 26,
   parameter int unsigned MODE       = 0,
   parameter int unsigned FRAC_SHIFT = 0,
   parameter int unsigned SAT        = 1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   input  logic                         acc_first,
   input  logic                         acc_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         ovf
);

   localparam int unsigned PW  = DIN0_WIDTH + DIN1_WIDTH;
   localparam int unsigned AMS = ACC_WIDTH - 1;

   logic                         en;
   logic                         take;
   logic signed [PW-1:0]         prod;
   logic [NUM_STAGE-1:0]         vld;
   logic [NUM_STAGE-1:0]         fst;
   logic [NUM_STAGE-1:0]         lst;
   logic signed [ACC_WIDTH-1:0]  prod_ext;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic                         acc_wrap;
   logic                         sticky;
   logic                         acc_done;
   logic                         fire_c;
   wide_t                        x_c;
   wide_t                        v_c;
   clip_t                        clip_c;
   logic signed [DOUT_WIDTH-1:0] dout_c;
   logic                         ovf_c;

   // One global enable stalls every stage while a result waits downstream.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign take     = in_valid && en;

   myproject_mac_mul_pipe #(
      .A_WIDTH   (DIN0_WIDTH),
      .B_WIDTH   (DIN1_WIDTH),
      .NUM_STAGE (NUM_STAGE)
   ) u_mul (
      .clk (ap_clk),
      .rst (ap_rst),
      .en  (en),
      .a   (din0),
      .b   (din1),
      .p   (prod)
   );

   // Beat qualifiers travel alongside the product.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         vld <= '0;
         fst <= '0;
         lst <= '0;
      end else if (en) begin
         vld[0] <= take;
         fst[0] <= acc_first;
         lst[0] <= acc_last;
         for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            vld[i] <= vld[i-1];
            fst[i] <= fst[i-1];
            lst[i] <= lst[i-1];
         end
      end
   end

   assign prod_ext = ACC_WIDTH'(prod);
   assign acc_sum  = acc + prod_ext;
   assign acc_wrap = (acc[AMS] == prod_ext[AMS]) && (acc_sum[AMS] != acc[AMS]);

   // Group accumulator; a first beat restarts the group and drops any open one.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         acc      <= '0;
         sticky   <= 1'b0;
         acc_done <= 1'b0;
      end else if (en && (MODE == MODE_ACC)) begin
         acc_done <= vld[NUM_STAGE-1] && lst[NUM_STAGE-1];
         if (vld[NUM_STAGE-1]) begin
            if (fst[NUM_STAGE-1]) begin
               acc    <= prod_ext;
               sticky <= 1'b0;
            end else begin
               acc    <= acc_sum;
               sticky <= sticky || acc_wrap;
            end
         end
      end
   end

   // Rounding shift followed by saturation or wrap to the result width.
   always_comb begin
      x_c    = (MODE == MODE_ACC) ? XW'(acc) : XW'(prod_ext);
      fire_c = (MODE == MODE_ACC) ? acc_done : vld[NUM_STAGE-1];
      v_c    = round_shift(x_c, FRAC_SHIFT);
      clip_c = sat_clip(v_c, DOUT_WIDTH);
      dout_c = DOUT_WIDTH'(v_c);
      ovf_c  = (XW'(dout_c) != v_c);
      if (SAT != 0) begin
         dout_c = DOUT_WIDTH'(clip_c.value);
         ovf_c  = clip_c.ovf;
      end
      if (MODE == MODE_ACC) ovf_c = ovf_c || sticky;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
      end else if (en) begin
         out_valid <= fire_c;
         if (fire_c) begin
            dout <= dout_c;
            ovf  <= ovf_c;
         end
      end
   end

endmodule
